parking_gate_ctrl: RTL and testbench

Gate-side terminal controller for the car parking system. It turns driver actions (entry button, ticket presented at exit) into the arrive/exit signal sequences the parking core expects. It issues a slot ticket with a per-slot exit code on entry and validates that ticket before releasing a car. It sits between the barrier/ticket hardware and the parking core, driving the core's `car_arrive`, `car_exit`, `exit_from` and `exit_code` inputs and observing its `can_park` and `register` outputs.

---
 rtl/parking_gate_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Gate-side terminal controller for the car parking system. Converts driver
//   actions into the arrive/exit handshakes the parking core expects. On
//   entry it issues a ticket carrying the slot the core assigned and a
//   per-slot code. On exit it validates the presented ticket before driving
//   the core's exit sequence, then opens the matching barrier.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   entry_btn       : driver entry request (sampled in IDLE)
//   exit_req        : ticket presented at exit (sampled in IDLE)
//   ticket_slot     : slot printed on the presented ticket
//   ticket_code     : code printed on the presented ticket
//   can_park        : core status, 1 when a slot is free
//   register        : core occupancy map, bit i = slot i occupied
//   car_arrive      : arrive strobe to core
//   car_exit        : exit request to core
//   exit_from       : exit slot to core
//   exit_code       : exit passcode to core
//   ticket_valid    : one-cycle pulse, issued_slot/issued_code valid
//   issued_slot     : slot assigned on entry, held until the next issue
//   issued_code     : ticket code for issued_slot
//   entry_gate_open : entry barrier open
//   exit_gate_open  : exit barrier open
//   deny            : one-cycle pulse, request refused
//   fault           : one-cycle pulse, core did not respond in time
//   busy            : high in every state except IDLE
module parking_gate_ctrl #(
  parameter logic [7:0] PASSCODE    = 8'd87,
  parameter int         TIMEOUT     = 16,
  parameter int         GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_btn,
  input  logic       exit_req,
  input  logic [2:0] ticket_slot,
  input  logic [7:0] ticket_code,
  input  logic       can_park,
  input  logic [7:0] register,
  output logic       car_arrive,
  output logic       car_exit,
  output logic [2:0] exit_from,
  output logic [7:0] exit_code,
  output logic       ticket_valid,
  output logic [2:0] issued_slot,
  output logic [7:0] issued_code,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       deny,
  output logic       fault,
  output logic       busy
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

  typedef enum logic [3:0] {
    IDLE, EN_ARR, EN_WAIT, EX_REQ, EX_CODE, EX_CLR, EX_DROP, EX_WAIT,
    GATE_EN, GATE_EX
  } state_t;

  state_t            state;
  logic [7:0]        snapshot;
  logic [2:0]        ex_slot;
  logic [CNT_W-1:0]  wait_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [7:0]        new_bits;
  logic [2:0]        new_slot;

  // Ticket code for a slot; wraps modulo 256.
  function automatic logic [7:0] slot_code(input logic [2:0] slot);
    return PASSCODE + {5'd0, slot};
  endfunction

  // Index of the lowest set bit (0 when none set).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Slots that became occupied since the entry request was accepted.
  assign new_bits = register & ~snapshot;
  assign new_slot = lowest_set(new_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      snapshot        <= 8'd0;
      ex_slot         <= 3'd0;
      wait_cnt        <= '0;
      gate_cnt        <= '0;
      car_arrive      <= 1'b0;
      car_exit        <= 1'b0;
      exit_from       <= 3'd0;
      exit_code       <= 8'd0;
      ticket_valid    <= 1'b0;
      issued_slot     <= 3'd0;
      issued_code     <= 8'd0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      deny            <= 1'b0;
      fault           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ticket_valid <= 1'b0;
      deny         <= 1'b0;
      fault        <= 1'b0;
      case (state)
        IDLE: begin
          // Exit wins arbitration; the losing entry request is dropped.
          if (exit_req) begin
            if (ticket_code == slot_code(ticket_slot) && register[ticket_slot]) begin
              ex_slot  <= ticket_slot;
              car_exit <= 1'b1;
              busy     <= 1'b1;
              state    <= EX_REQ;
            end else begin
              deny <= 1'b1;
            end
          end else if (entry_btn) begin
            if (!can_park || register == 8'hFF) begin
              deny <= 1'b1;
            end else begin
              snapshot   <= register;
              car_arrive <= 1'b1;
              busy       <= 1'b1;
              state      <= EN_ARR;
            end
          end
        end
        EN_ARR: begin
          car_arrive <= 1'b0;
          wait_cnt   <= '0;
          state      <= EN_WAIT;
        end
        EN_WAIT: begin
          if (new_bits != 8'd0) begin
            issued_slot     <= new_slot;
            issued_code     <= slot_code(new_slot);
            ticket_valid    <= 1'b1;
            entry_gate_open <= 1'b1;
            gate_cnt        <= GATE_ONE;
            state           <= GATE_EN;
          end else if (wait_cnt == TO_LAST) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EX_REQ: begin
          exit_from <= ex_slot;
          exit_code <= PASSCODE;
          state     <= EX_CODE;
        end
        EX_CODE: begin
          exit_from <= 3'd0;
          exit_code <= 8'd0;
          state     <= EX_CLR;
        end
        EX_CLR: begin
          car_exit <= 1'b0;
          state    <= EX_DROP;
        end
        EX_DROP: begin
          wait_cnt <= '0;
          state    <= EX_WAIT;
        end
        EX_WAIT: begin
          if (!register[ex_slot]) begin
            exit_gate_open <= 1'b1;
            gate_cnt       <= GATE_ONE;
            state          <= GATE_EX;
          end else if (wait_cnt == TO_LAST) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // gate_cnt counts open cycles already elapsed, including the current one.
        GATE_EN: begin
          if (gate_cnt == GATE_LAST) begin
            entry_gate_open <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        GATE_EX: begin
          if (gate_cnt == GATE_LAST) begin
            exit_gate_open <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl: per-cycle vector table of inputs and
// expected registered outputs, plus a hand-written mid-sequence reset check.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_btn, exit_req, can_park;
  logic [2:0] ticket_slot;
  logic [7:0] ticket_code, register;
  logic       car_arrive, car_exit, ticket_valid;
  logic [2:0] exit_from, issued_slot;
  logic [7:0] exit_code, issued_code;
  logic       entry_gate_open, exit_gate_open, deny, fault, busy;

  parking_gate_ctrl dut (
    .clk(clk), .rst(rst),
    .entry_btn(entry_btn), .exit_req(exit_req),
    .ticket_slot(ticket_slot), .ticket_code(ticket_code),
    .can_park(can_park), .register(register),
    .car_arrive(car_arrive), .car_exit(car_exit),
    .exit_from(exit_from), .exit_code(exit_code),
    .ticket_valid(ticket_valid), .issued_slot(issued_slot), .issued_code(issued_code),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .deny(deny), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output bundle: {car_arrive, car_exit, exit_from, exit_code, ticket_valid,
  //                 issued_slot, issued_code, entry_gate, exit_gate, deny, fault, busy}
  logic [29:0] act;
  assign act = {car_arrive, car_exit, exit_from, exit_code, ticket_valid,
                issued_slot, issued_code, entry_gate_open, exit_gate_open,
                deny, fault, busy};

  typedef struct {
    string       name;
    logic        eb;
    logic        er;
    logic [2:0]  ts;
    logic [7:0]  tc;
    logic        cp;
    logic [7:0]  rg;
    logic [29:0] expv;
  } vec_t;

  vec_t       vecs[$];
  int         applied = 0;
  int         miscompares = 0;
  logic [2:0] cur_is;
  logic [7:0] cur_ic;

  function automatic logic [29:0] pk(int ca, int ce, int ef, int ec, int tv,
                                     int eg, int xg, int dn, int ft, int bz);
    return {1'(ca), 1'(ce), 3'(ef), 8'(ec), 1'(tv), cur_is, cur_ic,
            1'(eg), 1'(xg), 1'(dn), 1'(ft), 1'(bz)};
  endfunction

  function automatic void add(string n, int eb, int er, int ts, int tc, int cp, int rg,
                              int ca, int ce, int ef, int ec, int tv,
                              int eg, int xg, int dn, int ft, int bz);
    vec_t v;
    v.name = n;
    v.eb   = 1'(eb);
    v.er   = 1'(er);
    v.ts   = 3'(ts);
    v.tc   = 8'(tc);
    v.cp   = 1'(cp);
    v.rg   = 8'(rg);
    v.expv = pk(ca, ce, ef, ec, tv, eg, xg, dn, ft, bz);
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [29:0] expv);
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: outputs got %h, expected %h", n, act, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    entry_btn = 1'b0; exit_req = 1'b0; can_park = 1'b0;
    ticket_slot = 3'd0; ticket_code = 8'd0; register = 8'd0;

    // ---------------- vector table ----------------
    cur_is = 3'd0; cur_ic = 8'd0;
    // Entry, core sets bit 0 two cycles after the arrive pulse.
    //   name        eb er ts tc cp rg     ca ce ef ec tv eg xg dn ft bz
    add("e1_btn",    1, 0, 0, 0, 1, 'h00,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("e1_arr",    0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("e1_wait",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cur_is = 3'd0; cur_ic = 8'd87;
    add("e1_issue",  0, 0, 0, 0, 1, 'h01,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      add("e1_gate", 0, 0, 0, 0, 1, 'h01,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add("e1_close",  0, 0, 0, 0, 1, 'h01,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Entry answered at the first wait edge with two new bits: lowest (2) wins.
    add("e2_btn",    1, 0, 0, 0, 1, 'h01,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("e2_arr",    0, 0, 0, 0, 1, 'h01,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cur_is = 3'd2; cur_ic = 8'd89;
    add("e2_issue",  0, 0, 0, 0, 1, 'h0D,  0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      add("e2_gate", 0, 0, 0, 0, 1, 'h0D,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add("e2_close",  0, 0, 0, 0, 1, 'h0D,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Denials, back to back.
    add("dn_full",   1, 0, 0, 0, 1, 'hFF,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("dn_idle",   0, 0, 0, 0, 1, 'hFF,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("dn_nopark", 1, 0, 0, 0, 0, 'h00,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("dn_code",   0, 1, 2, 88, 1, 'h04, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("dn_empty",  0, 1, 2, 89, 1, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("dn_idle2",  0, 0, 0, 0, 1, 'h04,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Valid exit from slot 2, core clears after EX_DROP.
    add("x_req",     0, 1, 2, 89, 1, 'h04, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("x_code",    0, 0, 0, 0, 1, 'h04,  0, 1, 2, 87, 0, 0, 0, 0, 0, 1);
    add("x_clr",     0, 0, 0, 0, 1, 'h04,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("x_drop",    0, 0, 0, 0, 1, 'h04,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("x_wait",    0, 0, 0, 0, 1, 'h04,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("x_clear",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      add("x_gate",  0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("x_close",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Entry and valid exit together: exit runs, entry (held high) is ignored.
    add("a_both",    1, 1, 3, 90, 1, 'h08, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("a_code",    1, 0, 0, 0, 1, 'h08,  0, 1, 3, 87, 0, 0, 0, 0, 0, 1);
    add("a_clr",     0, 0, 0, 0, 1, 'h08,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("a_drop",    0, 0, 0, 0, 1, 'h08,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("a_wait",    0, 0, 0, 0, 1, 'h08,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("a_clear",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      add("a_gate",  0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("a_close",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Exit where the core never clears slot 4: fault on the 16th wait edge.
    add("t_req",     0, 1, 4, 91, 1, 'h10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_code",    0, 0, 0, 0, 1, 'h10,  0, 1, 4, 87, 0, 0, 0, 0, 0, 1);
    add("t_clr",     0, 0, 0, 0, 1, 'h10,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_drop",    0, 0, 0, 0, 1, 'h10,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_enter",   0, 0, 0, 0, 1, 'h10,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++)
      add("t_wait",  0, 0, 0, 0, 1, 'h10,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_fault",   0, 0, 0, 0, 1, 'h10,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("t_idle",    0, 0, 0, 0, 1, 'h10,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Entry where the core never takes a slot: fault, no ticket.
    add("w_btn",     1, 0, 0, 0, 1, 'h00,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("w_arr",     0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++)
      add("w_wait",  0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("w_fault",   0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("w_idle",    0, 0, 0, 0, 1, 'h00,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 30'd0);
    rst = 1'b0;

    // ---------------- apply table ----------------
    foreach (vecs[k]) begin
      entry_btn   = vecs[k].eb;
      exit_req    = vecs[k].er;
      ticket_slot = vecs[k].ts;
      ticket_code = vecs[k].tc;
      can_park    = vecs[k].cp;
      register    = vecs[k].rg;
      @(posedge clk);
      @(negedge clk);
      check(vecs[k].name, vecs[k].expv);
    end

    // ---------------- reset during EX_CODE ----------------
    exit_req = 1'b1; ticket_slot = 3'd2; ticket_code = 8'd89; register = 8'h04;
    entry_btn = 1'b0; can_park = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rs_req", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    exit_req = 1'b0; ticket_slot = 3'd0; ticket_code = 8'd0;
    @(posedge clk);
    @(negedge clk);
    check("rs_code", pk(0, 1, 2, 87, 0, 0, 0, 0, 0, 1));
    #1 rst = 1'b1;
    #1 check("rs_async", 30'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_idle", 30'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
